scan_select_seq: RTL and testbench
==================================

# scan_select_seq

Sequencer that generates the 2-bit select feeding the 2-to-4 `decoder` stage. It steps through the four outputs in round-robin order, holds each for a programmable dwell time, and inserts a blanking gap between selections. It skips outputs masked off, and flags each complete pass. It sits directly upstream of the decoder. Downstream logic gates the decoder's one-hot output with `s_valid`.

## Interface
- `DWELL_W`, 16: width of the dwell-count input.
- `BLANK_CYC`, 2: blanking cycles inserted between consecutive selections; 0 is legal and means no gap.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  run enable; level-sensitive.
- `dwell`  in  DWELL_W  active cycles per selection; 0 is treated as 1.
- `mask`  in  4  per-index enable; bit i=1 means index i participates.
- `s`  out  2  select to the decoder.
- `s_valid`  out  1  high while `s` is in its active dwell window.
- `frame_done`  out  1  one-cycle pulse when a full pass over the enabled indices completes.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- All outputs are registered.
- Reset values:
  - state = IDLE
  - `s` = 2'b00
  - `s_valid` = 0
  - `frame_done` = 0
  - `busy` = 0
  - dwell and blank counters = 0
- **IDLE**
  - `s_valid` = 0; `s` holds its last value.
  - If `en`=1 and `mask`≠0 at an edge, go to ACTIVE.
  - `s` ← lowest set bit index of `mask`; `s_valid` ← 1; dwell counter loads `max(dwell,1)-1`.
- **ACTIVE**
  - `s_valid` = 1 and `s` is stable.
  - The dwell counter decrements each cycle.
  - When the counter reaches 0:
    - If `BLANK_CYC`>0: go to BLANK, `s_valid` ← 0, blank counter ← `BLANK_CYC-1`.
    - If `BLANK_CYC`=0: advance directly (see Advance).
- **BLANK**
  - `s_valid` = 0 and `s` holds the previous index.
  - When the blank counter reaches 0, advance.
- **Advance**
  - `mask` is sampled at this edge.
  - Next index = next set bit of `mask` above the current index, wrapping modulo 4. The current index itself is eligible if it is the only set bit.
  - Go to ACTIVE with `s_valid` ← 1 and the dwell counter reloaded from the current `dwell`.
  - If the search wrapped past index 3, or found the same index, `frame_done` pulses in the same cycle that `s_valid` rises for the new index.
  - If the sampled `mask` = 0, go to IDLE instead.
- `dwell` is sampled only on ACTIVE entry; changes mid-dwell take effect at the next selection.
- **`en` deassertion:** `en`=0 sampled in any state sends the block to IDLE on that edge. `s_valid` and `frame_done` are 0 the following cycle; the current dwell or blank is abandoned.
- **Reset mid-operation:** reset overrides everything and returns all outputs to their reset values on the next edge.
- **Simultaneous `rst`, `en`:** `rst` wins.

## Timing
- Start latency: `en` sampled high at edge N (from IDLE) → `s_valid`=1 after edge N.
- For each selection, `s_valid` is high for exactly `max(dwell,1)` consecutive cycles.
- This is followed by exactly `BLANK_CYC` cycles with `s_valid`=0.
- Selection period = `max(dwell,1)+BLANK_CYC` cycles.
- Frame period = k·(`max(dwell,1)+BLANK_CYC`) for k enabled indices.
- `s` changes only on the edge where `s_valid` goes 0→1, or on the ACTIVE→ACTIVE edge when `BLANK_CYC`=0. It never changes while `s_valid` is held high within one dwell.
- `busy` = 1 from the cycle after the start edge until the cycle after the IDLE-entry edge.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `en`=1 and `mask`=4'hF.
  - All outputs must be 0 during reset.
  - `s_valid` rises the cycle after `rst` drops.
- **Full scan:** `dwell`=3, `BLANK_CYC`=2, `mask`=4'hF.
  - `s` sequence is 0,1,2,3,0, each with 3 `s_valid` cycles then 2 blank cycles.
  - `frame_done` pulses exactly when `s` returns to 0; period is 20 cycles.
- **Mask skip:** `mask`=4'b1010, `dwell`=1.
  - `s` alternates 1,3,1.
  - `frame_done` pulses on each return to 1; `s` never equals 0 or 2 while `s_valid`=1.
- **Single index and dwell=0:** `mask`=4'b0100, `dwell`=0, `BLANK_CYC`=0.
  - `s`=2 continuously and `s_valid` stays high.
  - `frame_done` pulses every cycle after the first.
- **Mid-operation disable:** deassert `en` during the dwell of index 2.
  - Next cycle: `s_valid`=0, `busy`=0, `s`=2 held.
  - Re-asserting `en` restarts at the lowest enabled index.
- **Mask change:** change `mask` from 4'hF to 4'h0 during the BLANK after index 1.
  - Block enters IDLE at the advance edge with `s_valid`=0 and no `frame_done` pulse.

Source files
------------

// File: rtl/scan_select_seq.sv
// Round-robin select sequencer for the 2-to-4 decoder stage.
// Holds each enabled index for a dwell window, then blanks before advancing.
module scan_select_seq #(
   parameter int DWELL_W   = 16,
   parameter int BLANK_CYC = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [3:0]         mask,
   output logic [1:0]         s,
   output logic               s_valid,
   output logic               frame_done,
   output logic               busy
);

   localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
   localparam logic [BW-1:0] BLANK_LD =
      BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_BLANK
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         s_q, s_d;
   logic               s_valid_q, s_valid_d;
   logic               frame_done_q, frame_done_d;
   logic               busy_q, busy_d;
   logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [BW-1:0]      blank_cnt_q, blank_cnt_d;

   logic [DWELL_W-1:0] dwell_ld;
   logic [1:0]         first_idx;
   logic [1:0]         nxt_idx;
   logic               nxt_wrap;
   logic               adv;
   logic               mask_any;

   assign mask_any = |mask;
   assign dwell_ld = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

   always_comb begin
      first_idx = 2'd0;
      if (mask[0])      first_idx = 2'd0;
      else if (mask[1]) first_idx = 2'd1;
      else if (mask[2]) first_idx = 2'd2;
      else if (mask[3]) first_idx = 2'd3;
   end

   // Search upward from the current index; offset 4 lands back on itself.
   always_comb begin
      logic       found;
      logic [1:0] cand;
      found   = 1'b0;
      cand    = s_q;
      nxt_idx = s_q;
      for (int k = 1; k <= 4; k++) begin
         cand = s_q + 2'(k);
         if (!found && mask[cand]) begin
            found   = 1'b1;
            nxt_idx = cand;
         end
      end
      nxt_wrap = (nxt_idx <= s_q);
   end

   always_comb begin
      adv = 1'b0;
      if (state_q == ST_ACTIVE && dwell_cnt_q == '0 && BLANK_CYC == 0)
         adv = 1'b1;
      if (state_q == ST_BLANK && blank_cnt_q == '0)
         adv = 1'b1;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         s_q          <= 2'b00;
         s_valid_q    <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         dwell_cnt_q  <= '0;
         blank_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         s_valid_q    <= s_valid_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
         dwell_cnt_q  <= dwell_cnt_d;
         blank_cnt_q  <= blank_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mask_any) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (dwell_cnt_q == '0 && BLANK_CYC > 0)
                  state_d = ST_BLANK;
            end
            ST_BLANK: begin
               state_d = ST_BLANK;
            end
            default: state_d = ST_IDLE;
         endcase
         if (adv)
            state_d = mask_any ? ST_ACTIVE : ST_IDLE;
      end
   end

   // Output and counter logic
   always_comb begin
      s_d          = s_q;
      s_valid_d    = s_valid_q;
      frame_done_d = 1'b0;
      busy_d       = (state_d != ST_IDLE);
      dwell_cnt_d  = dwell_cnt_q;
      blank_cnt_d  = blank_cnt_q;
      if (!en) begin
         s_valid_d   = 1'b0;
         dwell_cnt_d = '0;
         blank_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               s_valid_d = 1'b0;
               if (mask_any) begin
                  s_d         = first_idx;
                  s_valid_d   = 1'b1;
                  dwell_cnt_d = dwell_ld;
               end
            end
            ST_ACTIVE: begin
               if (dwell_cnt_q != '0) begin
                  dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
               end else if (BLANK_CYC > 0) begin
                  s_valid_d   = 1'b0;
                  blank_cnt_d = BLANK_LD;
               end
            end
            ST_BLANK: begin
               if (blank_cnt_q != '0)
                  blank_cnt_d = blank_cnt_q - BW'(1);
            end
            default: s_valid_d = 1'b0;
         endcase
         if (adv) begin
            if (mask_any) begin
               s_d          = nxt_idx;
               s_valid_d    = 1'b1;
               frame_done_d = nxt_wrap;
               dwell_cnt_d  = dwell_ld;
            end else begin
               s_valid_d = 1'b0;
            end
         end
      end
   end

   assign s          = s_q;
   assign s_valid    = s_valid_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_scan_select_seq.sv
// Bench for scan_select_seq: two instances (blank 2 and blank 0) checked
// every cycle against a period-based model, plus directed literal checks.
module tb_scan_select_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] dwell;
   logic [3:0]  mask;

   logic [1:0] s_o    [2];
   logic       sv_o   [2];
   logic       fd_o   [2];
   logic       busy_o [2];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   scan_select_seq #(.DWELL_W(16), .BLANK_CYC(2)) u_b2 (
      .clk(clk), .rst(rst), .en(en), .dwell(dwell), .mask(mask),
      .s(s_o[0]), .s_valid(sv_o[0]), .frame_done(fd_o[0]),
      .busy(busy_o[0])
   );

   scan_select_seq #(.DWELL_W(16), .BLANK_CYC(0)) u_b0 (
      .clk(clk), .rst(rst), .en(en), .dwell(dwell), .mask(mask),
      .s(s_o[1]), .s_valid(sv_o[1]), .frame_done(fd_o[1]),
      .busy(busy_o[1])
   );

   // Model: position within the selection period decides everything.
   typedef struct {
      bit run;
      int s;
      int t;
      int dw;
      bit sv;
      bit fd;
   } mdl_t;

   mdl_t m [2];
   mdl_t mn[2];

   function automatic int blank_of(int i);
      return (i == 0) ? 2 : 0;
   endfunction

   function automatic int lowest(logic [3:0] mk);
      for (int i = 0; i < 4; i++)
         if (mk[i]) return i;
      return 0;
   endfunction

   function automatic int next_above(int cur, logic [3:0] mk);
      for (int k = 1; k <= 4; k++)
         if (mk[(cur + k) % 4]) return (cur + k) % 4;
      return cur;
   endfunction

   always_comb begin
      int nt;
      int ni;
      nt = 0;
      ni = 0;
      mn = m;
      for (int i = 0; i < 2; i++) begin
         mn[i].fd = 1'b0;
         if (rst) begin
            mn[i].run = 1'b0;
            mn[i].s   = 0;
            mn[i].t   = 0;
            mn[i].dw  = 0;
            mn[i].sv  = 1'b0;
         end else if (!en) begin
            mn[i].run = 1'b0;
            mn[i].sv  = 1'b0;
         end else if (!m[i].run) begin
            if (mask != 4'h0) begin
               mn[i].run = 1'b1;
               mn[i].s   = lowest(mask);
               mn[i].t   = 0;
               mn[i].dw  = (dwell == 0) ? 1 : int'(dwell);
               mn[i].sv  = 1'b1;
            end
         end else begin
            nt = m[i].t + 1;
            if (nt == m[i].dw + blank_of(i)) begin
               if (mask == 4'h0) begin
                  mn[i].run = 1'b0;
                  mn[i].sv  = 1'b0;
               end else begin
                  ni        = next_above(m[i].s, mask);
                  mn[i].fd  = (ni <= m[i].s);
                  mn[i].s   = ni;
                  mn[i].t   = 0;
                  mn[i].dw  = (dwell == 0) ? 1 : int'(dwell);
                  mn[i].sv  = 1'b1;
               end
            end else begin
               mn[i].t  = nt;
               mn[i].sv = (nt < m[i].dw);
            end
         end
      end
   end

   always @(posedge clk) m <= mn;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                  $time);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("model_s[%0d]", i), 32'(s_o[i]), m[i].s);
         chk($sformatf("model_sv[%0d]", i), 32'(sv_o[i]), 32'(m[i].sv));
         chk($sformatf("model_fd[%0d]", i), 32'(fd_o[i]), 32'(m[i].fd));
         chk($sformatf("model_busy[%0d]", i), 32'(busy_o[i]),
             32'(m[i].run));
      end
   end

   logic [1:0] rs[2][64];
   logic       rv[2][64];
   logic       rf[2][64];
   logic       rb[2][64];

   task automatic rec(int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            rs[i][c] = s_o[i];
            rv[i][c] = sv_o[i];
            rf[i][c] = fd_o[i];
            rb[i][c] = busy_o[i];
         end
      end
   endtask

   initial begin
      int cnt;
      rst   = 1'b1;
      en    = 1'b1;
      mask  = 4'hF;
      dwell = 16'd3;
      repeat (2) @(negedge clk);
      chk("rst_sv", 32'(sv_o[0]), 0);
      chk("rst_busy", 32'(busy_o[0]), 0);
      chk("rst_s", 32'(s_o[0]), 0);
      chk("rst_fd", 32'(fd_o[0]), 0);

      // Full scan, dwell 3
      rst = 1'b0;
      rec(41);
      chk("scan_start_sv", 32'(rv[0][0]), 1);
      chk("scan_s5", 32'(rs[0][5]), 1);
      chk("scan_blank3", 32'(rv[0][3]), 0);
      chk("scan_blank4", 32'(rv[0][4]), 0);
      chk("scan_s15", 32'(rs[0][15]), 3);
      chk("scan_fd0", 32'(rf[0][0]), 0);
      chk("scan_fd20", 32'(rf[0][20]), 1);
      chk("scan_s20", 32'(rs[0][20]), 0);
      cnt = 0;
      for (int c = 0; c < 41; c++) cnt += int'(rf[0][c]);
      chk("scan_fd_count", cnt, 2);
      chk("scan_b0_fd12", 32'(rf[1][12]), 1);
      chk("scan_b0_s9", 32'(rs[1][9]), 3);

      // Mask skip, dwell 1
      en = 1'b0;
      rec(1);
      mask  = 4'b1010;
      dwell = 16'd1;
      en    = 1'b1;
      rec(12);
      chk("skip_s0", 32'(rs[0][0]), 1);
      chk("skip_s3", 32'(rs[0][3]), 3);
      chk("skip_fd3", 32'(rf[0][3]), 0);
      chk("skip_fd6", 32'(rf[0][6]), 1);
      chk("skip_s6", 32'(rs[0][6]), 1);
      cnt = 0;
      for (int c = 0; c < 12; c++)
         if (rv[0][c] && !rs[0][c][0]) cnt++;
      chk("skip_even_sel", cnt, 0);
      chk("skip_b0_s1", 32'(rs[1][1]), 3);
      chk("skip_b0_fd2", 32'(rf[1][2]), 1);

      // Single index, dwell 0
      en = 1'b0;
      rec(1);
      mask  = 4'b0100;
      dwell = 16'd0;
      en    = 1'b1;
      rec(8);
      cnt = 0;
      for (int c = 0; c < 8; c++)
         if (rv[1][c] && rs[1][c] == 2'd2) cnt++;
      chk("single_hold", cnt, 8);
      chk("single_fd0", 32'(rf[1][0]), 0);
      cnt = 0;
      for (int c = 1; c < 8; c++) cnt += int'(rf[1][c]);
      chk("single_fd_each", cnt, 7);
      chk("single_b2_fd3", 32'(rf[0][3]), 1);

      // Disable during dwell of index 2
      en = 1'b0;
      rec(1);
      mask  = 4'hF;
      dwell = 16'd3;
      en    = 1'b1;
      rec(12);
      chk("dis_pre_s", 32'(rs[0][11]), 2);
      en = 1'b0;
      rec(1);
      chk("dis_sv", 32'(rv[0][0]), 0);
      chk("dis_busy", 32'(rb[0][0]), 0);
      chk("dis_s", 32'(rs[0][0]), 2);
      en = 1'b1;
      rec(1);
      chk("restart_s", 32'(rs[0][0]), 0);
      chk("restart_sv", 32'(rv[0][0]), 1);

      // Mask drops to zero during blank after index 1
      rec(8);
      chk("mc_blank_s", 32'(rs[0][7]), 1);
      mask = 4'h0;
      rec(2);
      chk("mc_busy9", 32'(rb[0][0]), 1);
      chk("mc_sv", 32'(rv[0][1]), 0);
      chk("mc_fd", 32'(rf[0][1]), 0);
      chk("mc_busy", 32'(rb[0][1]), 0);
      chk("mc_s", 32'(rs[0][1]), 1);

      // Reset mid-operation with en held high
      mask = 4'hF;
      rec(4);
      rst = 1'b1;
      rec(1);
      chk("mrst_sv", 32'(rv[0][0]), 0);
      chk("mrst_s", 32'(rs[0][0]), 0);
      chk("mrst_busy", 32'(rb[0][0]), 0);
      chk("mrst_b0_s", 32'(rs[1][0]), 0);
      rst = 1'b0;
      rec(1);
      chk("mrst_resume", 32'(rv[0][0]), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
